// File: rtl/mem_stage_pkg.sv
// Shared access-type constants and load/store lane helpers for the memory stage.
// Reused by decode/execute, so nothing here depends on the RAM geometry.
package mem_stage_pkg;

  localparam logic [2:0] ST_B  = 3'b000;
  localparam logic [2:0] ST_H  = 3'b001;
  localparam logic [2:0] ST_W  = 3'b010;
  localparam logic [2:0] ST_BU = 3'b100;
  localparam logic [2:0] ST_HU = 3'b101;

  // Unlisted codes (011/110/111) fall through to a full-word load.
  function automatic logic [31:0] load_ext(input logic [31:0] word,
                                           input logic [2:0]  f3,
                                           input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      ST_B:    load_ext = {{24{b[7]}}, b};
      ST_BU:   load_ext = {24'h0, b};
      ST_H:    load_ext = {{16{h[15]}}, h};
      ST_HU:   load_ext = {16'h0, h};
      default: load_ext = word;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3,
                                          input logic [1:0] off);
    case (f3[1:0])
      2'b00:   store_be = 4'b0001 << off;
      2'b01:   store_be = off[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_dmem.sv
// Word-organised data RAM: asynchronous read, synchronous byte-enabled write.
module dmem #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Reads see the pre-edge word, so a same-cycle load/store returns old data.
  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: data RAM access, branch resolve and the M/W pipeline register.
// Optional MEM_MISALIGN_CHECK_EN suppresses misaligned H/W accesses and flags them.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  strCtrlM,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        MemtoRegM,
  input  logic        PCBranchM,
  input  logic        branchM,
  input  logic [31:0] ALUoutM,
  input  logic [31:0] PCplusImmM,
  input  logic [31:0] r2M,
  input  logic [4:0]  rdM,
  output logic        PCSrcM,
  output logic [31:0] PCTargetM,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic [4:0]  rdW,
  output logic [31:0] ALUoutW,
  output logic [31:0] ReadDataW,
  output logic        misalignW
);

  logic [AW-1:0] word_idx;
  logic [1:0]    off;
  logic [31:0]   rd_word;
  logic [31:0]   wdata;
  logic [3:0]    be;
  logic          mis;
  logic          wr_en;
  logic          unused_addr_hi;

  assign word_idx       = ALUoutM[AW+1:2];
  assign off            = ALUoutM[1:0];
  assign unused_addr_hi = ^ALUoutM[31:AW+2];

  assign PCSrcM    = PCBranchM & branchM;
  assign PCTargetM = PCplusImmM;

`ifdef MEM_MISALIGN_CHECK_EN
  assign mis = (MemWriteM | MemtoRegM) &
               (((strCtrlM[1:0] == 2'b01) & off[0]) | (strCtrlM[1] & (off != 2'b00)));
`else
  assign mis = 1'b0;
`endif

  // Gating here keeps rst out of the RAM's clocked logic while still dropping reset-edge stores.
  assign wr_en = MemWriteM & ~rst & ~mis;
  assign be    = store_be(strCtrlM, off);

  always_comb begin
    wdata = r2M;
    case (strCtrlM[1:0])
      2'b00:   wdata = {4{r2M[7:0]}};
      2'b01:   wdata = {2{r2M[15:0]}};
      default: wdata = r2M;
    endcase
  end

  dmem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_dmem (
    .clk   (clk),
    .addr  (word_idx),
    .we    (wr_en),
    .be    (be),
    .wdata (wdata),
    .rdata (rd_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      rdW       <= 5'd0;
      ALUoutW   <= 32'd0;
      ReadDataW <= 32'd0;
      misalignW <= 1'b0;
    end else begin
      RegWriteW <= RegWriteM & ~(mis & MemtoRegM);
      MemtoRegW <= MemtoRegM;
      rdW       <= rdM;
      ALUoutW   <= ALUoutM;
      ReadDataW <= load_ext(rd_word, strCtrlM, off);
      misalignW <= mis;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ops push expected W values, a monitor pops and compares.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic [2:0]  strCtrlM;
  logic        RegWriteM, MemWriteM, MemtoRegM, PCBranchM, branchM;
  logic [31:0] ALUoutM, PCplusImmM, r2M;
  logic [4:0]  rdM;
  logic        PCSrcM;
  logic [31:0] PCTargetM;
  logic        RegWriteW, MemtoRegW;
  logic [4:0]  rdW;
  logic [31:0] ALUoutW, ReadDataW;
  logic        misalignW;

  typedef struct {
    logic        rw;
    logic        m2r;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic        chk_rdata;
    logic        mis;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  mem_stage #(.DEPTH(1024)) dut (
    .clk(clk), .rst(rst), .strCtrlM(strCtrlM), .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM), .PCBranchM(PCBranchM),
    .branchM(branchM), .ALUoutM(ALUoutM), .PCplusImmM(PCplusImmM), .r2M(r2M),
    .rdM(rdM), .PCSrcM(PCSrcM), .PCTargetM(PCTargetM), .RegWriteW(RegWriteW),
    .MemtoRegW(MemtoRegW), .rdW(rdW), .ALUoutW(ALUoutW), .ReadDataW(ReadDataW),
    .misalignW(misalignW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    strCtrlM   = ST_W;
    RegWriteM  = 1'b0;
    MemWriteM  = 1'b0;
    MemtoRegM  = 1'b0;
    PCBranchM  = 1'b0;
    branchM    = 1'b0;
    ALUoutM    = 32'h0;
    PCplusImmM = 32'h0;
    r2M        = 32'h0;
    rdM        = 5'd0;
  endtask

  task automatic op(input logic [2:0] f3, input logic we, input logic mr, input logic rw,
                    input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd,
                    input logic chk, input logic [31:0] exp_rd);
    exp_t e;
    logic mis;
    @(negedge clk);
    strCtrlM  = f3;
    MemWriteM = we;
    MemtoRegM = mr;
    RegWriteM = rw;
    ALUoutM   = addr;
    r2M       = data;
    rdM       = rd;
    mis = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
    if (we | mr) mis = ((f3[1:0] == 2'b01) && addr[0]) || (f3[1] && (addr[1:0] != 2'b00));
`endif
    e.rw        = rw & ~(mis & mr);
    e.m2r       = mr;
    e.rd        = rd;
    e.alu       = addr;
    e.rdata     = exp_rd;
    e.chk_rdata = chk;
    e.mis       = mis;
    q.push_back(e);
  endtask

  task automatic sw(input logic [31:0] addr, input logic [31:0] data);
    op(ST_W, 1'b1, 1'b0, 1'b0, addr, data, 5'd0, 1'b0, 32'h0);
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                    input logic [31:0] exp_rd);
    op(f3, 1'b0, 1'b1, 1'b1, addr, 32'h0, rd, 1'b1, exp_rd);
  endtask

  task automatic chk_w_zero(input string tag);
    chk32({tag, "_regwrite"}, 32'(RegWriteW), 32'h0);
    chk32({tag, "_memtoreg"}, 32'(MemtoRegW), 32'h0);
    chk32({tag, "_rd"},       32'(rdW),       32'h0);
    chk32({tag, "_aluout"},   ALUoutW,        32'h0);
    chk32({tag, "_readdata"}, ReadDataW,      32'h0);
    chk32({tag, "_misalign"}, 32'(misalignW), 32'h0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk32("regwrite_w", 32'(RegWriteW), 32'(e.rw));
        chk32("memtoreg_w", 32'(MemtoRegW), 32'(e.m2r));
        chk32("rd_w",       32'(rdW),       32'(e.rd));
        chk32("aluout_w",   ALUoutW,        e.alu);
        chk32("misalign_w", 32'(misalignW), 32'(e.mis));
        if (e.chk_rdata) chk32("readdata_w", ReadDataW, e.rdata);
      end
    end
  end

  initial begin : stim
    logic [31:0] exp_lw40, exp_lh43;
    int wait_cyc;
`ifdef MEM_MISALIGN_CHECK_EN
    exp_lw40 = 32'h55667788;
    exp_lh43 = 32'h00005566;
`else
    exp_lw40 = 32'hCAFEF00D;
    exp_lh43 = 32'hFFFFCAFE;
`endif
    rst = 1'b1;
    idle();
    #2;
    chk_w_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    sw(32'h10, 32'hDEADBEEF);
    ld(ST_W, 32'h10, 5'd1, 32'hDEADBEEF);

    sw(32'h20, 32'h80FF7F01);
    ld(ST_B,  32'h23, 5'd2, 32'hFFFFFF80);
    ld(ST_BU, 32'h23, 5'd3, 32'h00000080);
    ld(ST_H,  32'h22, 5'd4, 32'hFFFF80FF);
    ld(ST_HU, 32'h20, 5'd5, 32'h00007F01);
    ld(ST_B,  32'h21, 5'd6, 32'h0000007F);

    sw(32'h30, 32'h11223344);
    op(ST_B, 1'b1, 1'b0, 1'b0, 32'h31, 32'h123456AA, 5'd0, 1'b0, 32'h0);
    ld(ST_W, 32'h30, 5'd7, 32'h1122AA44);
    op(ST_H, 1'b1, 1'b0, 1'b0, 32'h32, 32'h9999BBCC, 5'd0, 1'b0, 32'h0);
    ld(ST_W, 32'h30, 5'd8, 32'hBBCCAA44);

    // Load and store in the same cycle: the load sees the old word.
    sw(32'h50, 32'hA5A5A5A5);
    op(ST_W, 1'b1, 1'b1, 1'b1, 32'h50, 32'h01020304, 5'd9, 1'b1, 32'hA5A5A5A5);
    ld(ST_W, 32'h50, 5'd10, 32'h01020304);

    sw(32'h1000, 32'h0BADF00D);
    ld(ST_W, 32'h0, 5'd11, 32'h0BADF00D);

    sw(32'h40, 32'h55667788);
    sw(32'h41, 32'hCAFEF00D);
    ld(ST_W, 32'h40, 5'd12, exp_lw40);
    ld(ST_H, 32'h43, 5'd13, exp_lh43);

    @(negedge clk);
    idle();
    PCBranchM  = 1'b1;
    branchM    = 1'b1;
    PCplusImmM = 32'h100;
    #1;
    chk32("pcsrc_taken",  32'(PCSrcM), 32'h1);
    chk32("pctarget",     PCTargetM,   32'h100);
    branchM = 1'b0;
    #1;
    chk32("pcsrc_nottaken", 32'(PCSrcM), 32'h0);
    PCBranchM  = 1'b0;
    branchM    = 1'b1;
    PCplusImmM = 32'h2468;
    #1;
    chk32("pcsrc_nobranch", 32'(PCSrcM), 32'h0);
    chk32("pctarget2",      PCTargetM,   32'h2468);

    ld(ST_W, 32'h10, 5'd14, 32'hDEADBEEF);
    @(negedge clk);
    strCtrlM  = ST_W;
    MemWriteM = 1'b1;
    MemtoRegM = 1'b0;
    RegWriteM = 1'b0;
    ALUoutM   = 32'h10;
    r2M       = 32'h12345678;
    rdM       = 5'd0;
    #2;
    rst = 1'b1;
    #1;
    chk_w_zero("midreset");
    @(negedge clk);
    idle();
    rst = 1'b0;
    ld(ST_W, 32'h10, 5'd15, 32'hDEADBEEF);

    @(negedge clk);
    idle();
    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d pending expectations, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage RV32I pipeline, directly downstream of execute. Consumes the registered E/M controls and operands, performs byte/half/word loads and stores against an internal word-organised data RAM, and resolves the branch decision. It then registers everything writeback needs into the M/W pipeline register.

## Interface
- DEPTH, 1024: data RAM size in 32-bit words; power of two.
- AW, $clog2(DEPTH): word-address width.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- strCtrlM  in  3  access type, funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- RegWriteM, MemWriteM, MemtoRegM  in  1 each  control bits from E/M register.
- PCBranchM  in  1  instruction is a branch/jump.
- branchM  in  1  ALU branch condition true.
- ALUoutM  in  32  ALU result / effective byte address.
- PCplusImmM  in  32  branch target.
- r2M  in  32  store data.
- rdM  in  5  destination register.
- PCSrcM  out  1  combinational, PCBranchM & branchM.
- PCTargetM  out  32  combinational, equals PCplusImmM.
- RegWriteW, MemtoRegW  out  1 each  registered controls.
- rdW  out  5  registered rd.
- ALUoutW  out  32  registered ALU result.
- ReadDataW  out  32  registered, extended load data.
- misalignW  out  1  registered misaligned-access flag (see Configuration).

## Operation
- Word index = ALUoutM[AW+1:2]; upper address bits ignored, so the access wraps modulo DEPTH words. Byte offset = ALUoutM[1:0].
- RAM read is asynchronous: the addressed word is read combinationally in the same cycle.
- Load extraction: B/BU select byte at offset (bits 8*off+7:8*off), sign- or zero-extended to 32 bits. H/HU select halfword at ALUoutM[1], sign- or zero-extended. W passes the word. Codes 011/110/111 are treated as W.
- Stores happen at posedge clk when MemWriteM=1, with byte enables:
  - SB: one lane at the offset, data r2M[7:0] replicated.
  - SH: lanes {1,0} or {3,2} by ALUoutM[1], data r2M[15:0].
  - SW: all lanes.
  - Unselected lanes are unchanged.
- Load/store to the same address in one cycle: the load returns the OLD word; the new data is visible from the next cycle.
- ReadDataW is captured every cycle regardless of MemtoRegM; writeback mux selects it.
- RAM contents are not reset and are undefined after power-up; the bench preloads through the hierarchy or by stores.

## Timing
- M/W register: 1-cycle latency from M inputs to W outputs; updated every posedge, with no stall or enable.
- rst asserted: RegWriteW=0, MemtoRegW=0, rdW=0, ALUoutW=0, ReadDataW=0, misalignW=0 immediately (asynchronously).
- RAM writes are inhibited while rst=1. Reset mid-store: a store whose edge coincides with rst high is dropped.
- PCSrcM and PCTargetM have zero latency; they are valid in the same cycle as the M inputs.
- Store commits at the posedge ending its M cycle. A load in the next cycle to the same address sees the stored data.

## Configuration
- MEM_MISALIGN_CHECK_EN defined: an access is misaligned when H/HU has ALUoutM[0]=1, or W has ALUoutM[1:0]≠0.
  - A misaligned store writes nothing.
  - A misaligned load forces RegWriteW=0.
  - misalignW=1 for that instruction's W cycle.
  - Non-memory instructions (MemWriteM=0 and MemtoRegM=0) never flag.
- Not defined:
  - Offset bits irrelevant to the width are ignored: W uses offset 0, H uses ALUoutM[1] only.
  - Access proceeds normally.
  - misalignW is tied to 0.

## Structure
- Shared package holds the strCtrl funct3 constants (ST_B, ST_H, ST_W, ST_BU, ST_HU) and the load-extension function, so decode and execute can reuse them.
- One sub-module, dmem: DEPTH×32 RAM with async read, sync write and a 4-bit byte-enable input. Lane selection and extension stay in mem_stage.

## Test plan
- Word store/load: SW r2M=0xDEADBEEF at addr 0x10, next cycle LW addr 0x10 → ReadDataW=0xDEADBEEF one cycle later; MemtoRegW=1.
- Byte/half extension: word 0x80FF7F01 at 0x20.
  - LB @0x23 → 0xFFFFFF80.
  - LBU @0x23 → 0x00000080.
  - LH @0x22 → 0xFFFF80FF.
  - LHU @0x20 → 0x00007F01.
- Partial store: word 0x11223344 at 0x30, SB r2M=0xAA @0x31 → word becomes 0x1122AA44. Then SH r2M=0xBBCC @0x32 → 0xBBCCAA44.
- Branch resolve: PCBranchM=1, branchM=1, PCplusImmM=0x100 → PCSrcM=1 and PCTargetM=0x100 in the same cycle. With branchM=0 → PCSrcM=0.
- Wrap and reset: with DEPTH=1024, SW @0x1000 aliases word 0 (LW @0x0 returns the data). Asserting rst mid-cycle clears all W outputs immediately, and a store on that edge leaves RAM unchanged.
- Misalignment, with MEM_MISALIGN_CHECK_EN defined: SW @0x41 leaves the word unchanged and gives misalignW=1. LH @0x43 with RegWriteM=1 gives RegWriteW=0 and misalignW=1. Without the macro, SW @0x41 writes word 0x40.
